// File: rtl/uart_word_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_word_serializer
//  Description : Transmit-side word-to-byte serializer. Buffers 32-bit words
//                from the core in a small FIFO and feeds them one byte at a
//                time to a byte-wide UART transmitter using a wr/din/ready
//                handshake. Little-endian by default, so a host receives the
//                bytes in the same order it uses to load memory images.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DEPTH      word FIFO depth (power of 2, >= 2)
//    BYTES      bytes sent per word (1..4); upper bytes are dropped when < 4
//    LSB_FIRST  1: byte[7:0] goes first; 0: byte[8*BYTES-1 -: 8] goes first
//  Ports
//    clk         in   clock
//    reset       in   synchronous, active-high reset
//    s_data      in   [31:0] word to transmit
//    s_valid     in   s_data valid; accepted when s_valid & s_ready
//    s_ready     out  FIFO not full
//    tx_din      out  [7:0] byte to the UART transmitter
//    tx_wr       out  one-cycle kick to the UART transmitter
//    tx_ready    in   UART transmitter idle
//    level       out  [$clog2(DEPTH):0] words in FIFO (excludes word in flight)
//    busy        out  serializer active or words pending
//    words_sent  out  [31:0] fully transmitted words, wraps at 2^32
// ============================================================================
module uart_word_serializer #(
   parameter int DEPTH     = 16,
   parameter int BYTES     = 4,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [31:0]             s_data,
   input  logic                    s_valid,
   output logic                    s_ready,
   output logic [7:0]              tx_din,
   output logic                    tx_wr,
   input  logic                    tx_ready,
   output logic [$clog2(DEPTH):0]  level,
   output logic                    busy,
   output logic [31:0]             words_sent
);

   localparam int             c_AW       = $clog2(DEPTH);
   localparam logic [c_AW:0]  c_FULL     = (c_AW + 1)'(DEPTH);
   localparam logic [1:0]     c_LAST_IDX = 2'(BYTES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_KICK  = 2'd1,
      S_GUARD = 2'd2,
      S_WAIT  = 2'd3
   } state_t;

   // ------------------------------------------------------------------------
   // Word FIFO
   // ------------------------------------------------------------------------
   logic [31:0]      r_mem [DEPTH];
   logic [c_AW-1:0]  r_wr_ptr;
   logic [c_AW-1:0]  r_rd_ptr;
   logic [c_AW:0]    r_level;

   state_t           r_state;
   logic [31:0]      r_shift;
   logic [1:0]       r_byte_idx;
   logic [7:0]       r_tx_din;
   logic             r_tx_wr;
   logic [31:0]      r_words_sent;

   logic             w_push;
   logic             w_pop;
   logic [1:0]       w_byte_pos;
   logic [7:0]       w_sel_byte;

   // s_ready comes straight from the registered level, so a push presented
   // while full is simply never accepted (no overwrite, no combinational
   // path from the pop side).
   assign s_ready = (r_level != c_FULL);
   assign w_push  = s_valid & s_ready;
   // Pop only from IDLE and only when a word is stored, which also rules out
   // a push+pop pair on an empty FIFO.
   assign w_pop   = (r_state == S_IDLE) && (r_level != '0);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= s_data;
      end
   end

   // Pointers are c_AW bits wide, so they wrap modulo DEPTH on their own.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Byte selection: byte_idx counts transmitted bytes; the byte position
   // inside the word depends on the transmit order.
   // ------------------------------------------------------------------------
   generate
      if (LSB_FIRST) begin : g_lsb_first
         assign w_byte_pos = r_byte_idx;
      end else begin : g_msb_first
         assign w_byte_pos = c_LAST_IDX - r_byte_idx;
      end
   endgenerate

   assign w_sel_byte = r_shift[{w_byte_pos, 3'b000} +: 8];

   // ------------------------------------------------------------------------
   // Transmit FSM
   //   IDLE  -> pop a word, restart the byte index
   //   KICK  -> wait for tx_ready, then pulse tx_wr with the selected byte
   //   GUARD -> one cycle where tx_ready is ignored; the transmitter needs a
   //            cycle to drop ready after a kick
   //   WAIT  -> wait for the transmitter to finish the byte; the word is
   //            counted only once its last byte has completed
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_shift      <= '0;
         r_byte_idx   <= '0;
         r_tx_din     <= '0;
         r_tx_wr      <= 1'b0;
         r_words_sent <= '0;
      end else begin
         // tx_wr is a single-cycle pulse; only KICK raises it.
         r_tx_wr <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (r_level != '0) begin
                  r_shift    <= r_mem[r_rd_ptr];
                  r_byte_idx <= '0;
                  r_state    <= S_KICK;
               end
            end
            S_KICK: begin
               if (tx_ready) begin
                  r_tx_wr  <= 1'b1;
                  r_tx_din <= w_sel_byte;
                  r_state  <= S_GUARD;
               end
            end
            S_GUARD: begin
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (tx_ready) begin
                  if (r_byte_idx == c_LAST_IDX) begin
                     r_words_sent <= r_words_sent + 32'd1;
                     r_state      <= S_IDLE;
                  end else begin
                     r_byte_idx <= r_byte_idx + 2'd1;
                     r_state    <= S_KICK;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign tx_din     = r_tx_din;
   assign tx_wr      = r_tx_wr;
   assign level      = r_level;
   assign busy       = (r_state != S_IDLE) || (r_level != '0);
   assign words_sent = r_words_sent;

endmodule
`default_nettype wire

// File: tb/tb_uart_word_serializer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_uart_word_serializer
//  Description : Scoreboard bench for uart_word_serializer. Two instances:
//                dut_a (DEPTH=16, BYTES=4, LSB first) and dut_b (DEPTH=4,
//                BYTES=2, MSB first). Stimulus pushes expected bytes into a
//                queue per instance; a monitor pops and compares on tx_wr.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_word_serializer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   // instance A signals
   logic [31:0] a_s_data;
   logic        a_s_valid;
   logic        a_s_ready;
   logic [7:0]  a_tx_din;
   logic        a_tx_wr;
   logic        a_tx_ready;
   logic [4:0]  a_level;
   logic        a_busy;
   logic [31:0] a_words_sent;

   // instance B signals
   logic [31:0] b_s_data;
   logic        b_s_valid;
   logic        b_s_ready;
   logic [7:0]  b_tx_din;
   logic        b_tx_wr;
   logic        b_tx_ready;
   logic [2:0]  b_level;
   logic        b_busy;
   logic [31:0] b_words_sent;

   int checks = 0;
   int errors = 0;

   logic [7:0] q_a[$];
   logic [7:0] q_b[$];

   uart_word_serializer #(.DEPTH(16), .BYTES(4), .LSB_FIRST(1'b1)) dut_a (
      .clk        (clk),
      .reset      (reset),
      .s_data     (a_s_data),
      .s_valid    (a_s_valid),
      .s_ready    (a_s_ready),
      .tx_din     (a_tx_din),
      .tx_wr      (a_tx_wr),
      .tx_ready   (a_tx_ready),
      .level      (a_level),
      .busy       (a_busy),
      .words_sent (a_words_sent)
   );

   uart_word_serializer #(.DEPTH(4), .BYTES(2), .LSB_FIRST(1'b0)) dut_b (
      .clk        (clk),
      .reset      (reset),
      .s_data     (b_s_data),
      .s_valid    (b_s_valid),
      .s_ready    (b_s_ready),
      .tx_din     (b_tx_din),
      .tx_wr      (b_tx_wr),
      .tx_ready   (b_tx_ready),
      .level      (b_level),
      .busy       (b_busy),
      .words_sent (b_words_sent)
   );

   // ------------------------------------------------------------------------
   // UART transmitter models: ready drops one cycle after a kick and stays
   // low for 10 cycles. a_hold forces ready low, a_always forces it high.
   // ------------------------------------------------------------------------
   int   a_cnt = 0;
   int   b_cnt = 0;
   logic a_hold = 1'b0;
   logic a_always = 1'b0;

   always @(posedge clk) begin
      if (a_tx_wr)        a_cnt <= 10;
      else if (a_cnt > 0) a_cnt <= a_cnt - 1;
      if (b_tx_wr)        b_cnt <= 10;
      else if (b_cnt > 0) b_cnt <= b_cnt - 1;
   end

   assign a_tx_ready = a_always | ((a_cnt == 0) & ~a_hold);
   assign b_tx_ready = (b_cnt == 0);

   // ------------------------------------------------------------------------
   // Checking helpers and monitors
   // ------------------------------------------------------------------------
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   // tx_ready as seen at the edge that produced a kick
   logic a_ready_edge = 1'b1;
   logic b_ready_edge = 1'b1;
   logic a_prev_wr = 1'b0;
   logic b_prev_wr = 1'b0;

   always @(posedge clk) begin
      a_ready_edge <= a_tx_ready;
      b_ready_edge <= b_tx_ready;
   end

   always @(negedge clk) begin
      if (a_tx_wr) begin
         if (q_a.size() == 0) begin
            timeout_fail("a_unexpected_tx_wr");
            $display("FAIL a_unexpected_tx_wr: tx_din=%h with no byte expected", a_tx_din);
         end else begin
            check("a_tx_din", {24'd0, a_tx_din}, {24'd0, q_a.pop_front()});
         end
         check("a_no_adjacent_wr", {31'd0, a_prev_wr}, 32'd0);
         check("a_kick_with_ready", {31'd0, a_ready_edge}, 32'd1);
      end
      a_prev_wr <= a_tx_wr;
   end

   always @(negedge clk) begin
      if (b_tx_wr) begin
         if (q_b.size() == 0) begin
            timeout_fail("b_unexpected_tx_wr");
            $display("FAIL b_unexpected_tx_wr: tx_din=%h with no byte expected", b_tx_din);
         end else begin
            check("b_tx_din", {24'd0, b_tx_din}, {24'd0, q_b.pop_front()});
         end
         check("b_no_adjacent_wr", {31'd0, b_prev_wr}, 32'd0);
         check("b_kick_with_ready", {31'd0, b_ready_edge}, 32'd1);
      end
      b_prev_wr <= b_tx_wr;
   end

   // ------------------------------------------------------------------------
   // Stimulus tasks (entered and left on a falling edge, s_valid left high)
   // ------------------------------------------------------------------------
   task automatic push_a(input logic [31:0] w, input bit expect_bytes);
      int n = 0;
      a_s_valid = 1'b1;
      a_s_data  = w;
      while (!a_s_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!a_s_ready) begin
         timeout_fail("a_push");
      end else begin
         if (expect_bytes) begin
            for (int b = 0; b < 4; b++) q_a.push_back(w[8*b +: 8]);
         end
         @(negedge clk);
      end
   endtask

   // instance B sends the low two bytes, most significant first
   task automatic push_b(input logic [31:0] w);
      int n = 0;
      b_s_valid = 1'b1;
      b_s_data  = w;
      while (!b_s_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!b_s_ready) begin
         timeout_fail("b_push");
      end else begin
         q_b.push_back(w[15:8]);
         q_b.push_back(w[7:0]);
         @(negedge clk);
      end
   endtask

   task automatic wait_idle_a(input int bound);
      int n = 0;
      while ((a_busy || q_a.size() != 0) && n < bound) begin
         @(negedge clk);
         n++;
      end
      if (a_busy || q_a.size() != 0) timeout_fail("a_wait_idle");
   endtask

   task automatic wait_idle_b(input int bound);
      int n = 0;
      while ((b_busy || q_b.size() != 0) && n < bound) begin
         @(negedge clk);
         n++;
      end
      if (b_busy || q_b.size() != 0) timeout_fail("b_wait_idle");
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      q_a.delete();
      q_b.delete();
   endtask

   // ------------------------------------------------------------------------
   // Watchdog
   // ------------------------------------------------------------------------
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // ------------------------------------------------------------------------
   // Directed sequence
   // ------------------------------------------------------------------------
   initial begin
      int wait_n;
      reset     = 1'b1;
      a_s_valid = 1'b0;
      a_s_data  = '0;
      b_s_valid = 1'b0;
      b_s_data  = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // reset state
      check("rst_level",      {27'd0, a_level}, 32'd0);
      check("rst_s_ready",    {31'd0, a_s_ready}, 32'd1);
      check("rst_tx_wr",      {31'd0, a_tx_wr}, 32'd0);
      check("rst_tx_din",     {24'd0, a_tx_din}, 32'd0);
      check("rst_busy",       {31'd0, a_busy}, 32'd0);
      check("rst_words_sent", a_words_sent, 32'd0);
      check("rst_b_level",    {29'd0, b_level}, 32'd0);
      check("rst_b_s_ready",  {31'd0, b_s_ready}, 32'd1);

      // 1: single word, LSB first: 11 22 33 44, first kick two cycles after write
      push_a(32'h4433_2211, 1'b1);
      a_s_valid = 1'b0;
      check("t1_level_after_push", {27'd0, a_level}, 32'd1);
      check("t1_busy_after_push",  {31'd0, a_busy}, 32'd1);
      check("t1_wr_write_cycle",   {31'd0, a_tx_wr}, 32'd0);
      @(negedge clk);
      check("t1_wr_pop_cycle",     {31'd0, a_tx_wr}, 32'd0);
      check("t1_level_after_pop",  {27'd0, a_level}, 32'd0);
      @(negedge clk);
      check("t1_wr_kick_cycle",    {31'd0, a_tx_wr}, 32'd1);
      wait_idle_a(1000);
      check("t1_words_sent", a_words_sent, 32'd1);
      check("t1_busy_end",   {31'd0, a_busy}, 32'd0);

      // 2: BYTES=2, MSB first: AABBCCDD -> CC DD
      @(negedge clk);
      push_b(32'hAABB_CCDD);
      push_b(32'h1234_5678);
      b_s_valid = 1'b0;
      wait_idle_b(1000);
      check("t2_words_sent", b_words_sent, 32'd2);
      check("t2_busy_end",   {31'd0, b_busy}, 32'd0);

      // 3: transmitter stuck busy; one word parks in the shift register,
      // 16 more fill the FIFO, a further push is refused
      a_hold = 1'b1;
      for (int i = 0; i < 17; i++) begin
         push_a(32'hA000_0000 | (32'(i) << 16) | (32'(i) << 8) | 32'(i), 1'b1);
         if (i == 15) check("t3_level_15", {27'd0, a_level}, 32'd15);
      end
      a_s_valid = 1'b0;
      check("t3_level_full",   {27'd0, a_level}, 32'd16);
      check("t3_s_ready_full", {31'd0, a_s_ready}, 32'd0);
      check("t3_no_kick_held", {31'd0, a_tx_wr}, 32'd0);
      a_s_valid = 1'b1;
      a_s_data  = 32'hDEAD_BEEF;
      @(negedge clk);
      a_s_valid = 1'b0;
      check("t3_level_after_drop", {27'd0, a_level}, 32'd16);
      a_hold = 1'b0;
      wait_idle_a(5000);
      check("t3_words_sent", a_words_sent, 32'd18);

      // 4: reset after the second byte of a word with three more queued
      push_a(32'h0A0B_0C0D, 1'b1);
      push_a(32'h1111_1111, 1'b0);
      push_a(32'h2222_2222, 1'b0);
      push_a(32'h3333_3333, 1'b0);
      a_s_valid = 1'b0;
      wait_n = 0;
      while (q_a.size() > 2 && wait_n < 500) begin
         @(negedge clk);
         wait_n++;
      end
      if (q_a.size() > 2) timeout_fail("t4_second_byte");
      check("t4_level_before_rst", {27'd0, a_level}, 32'd3);
      pulse_reset();
      check("t4_level",      {27'd0, a_level}, 32'd0);
      check("t4_s_ready",    {31'd0, a_s_ready}, 32'd1);
      check("t4_busy",       {31'd0, a_busy}, 32'd0);
      check("t4_words_sent", a_words_sent, 32'd0);
      check("t4_tx_din",     {24'd0, a_tx_din}, 32'd0);
      repeat (40) @(negedge clk);
      push_a(32'h0102_0304, 1'b1);
      a_s_valid = 1'b0;
      wait_idle_a(1000);
      check("t4_words_after", a_words_sent, 32'd1);

      // 5: back-to-back words 0..7 with tx_ready always high
      pulse_reset();
      a_always = 1'b1;
      for (int i = 0; i < 8; i++) push_a(32'(i), 1'b1);
      a_s_valid = 1'b0;
      wait_idle_a(2000);
      check("t5_words_sent", a_words_sent, 32'd8);
      a_always = 1'b0;

      // 6: counter wrap
      @(negedge clk);
      force dut_a.r_words_sent = 32'hFFFF_FFFF;
      #1;
      release dut_a.r_words_sent;
      check("t6_preset", a_words_sent, 32'hFFFF_FFFF);
      @(negedge clk);
      push_a(32'h5566_7788, 1'b1);
      a_s_valid = 1'b0;
      wait_idle_a(1000);
      check("t6_wrap", a_words_sent, 32'd0);

      repeat (5) @(negedge clk);
      check("end_q_a_empty", 32'(q_a.size()), 32'd0);
      check("end_q_b_empty", 32'(q_b.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
